// File: rtl/branch_hazard_ctrl_pkg.sv
// rtl/branch_hazard_ctrl_pkg.sv - shared select codes, FSM state type and forward-select helper
package branch_hazard_ctrl_pkg;

    localparam logic [2:0] NPC_SEQ     = 3'b000;
    localparam logic [2:0] NPC_BR      = 3'b001;
    localparam logic [2:0] NPC_RESTORE = 3'b010;
    localparam logic [2:0] NPC_J       = 3'b011;
    localparam logic [2:0] NPC_JR      = 3'b100;

    localparam logic [1:0] FWD_RF    = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b01;
    localparam logic [1:0] FWD_MEMWB = 2'b10;

    localparam logic [2:0] JMP_J    = 3'b010;
    localparam logic [2:0] JMP_JAL  = 3'b111;
    localparam logic [2:0] JMP_JR   = 3'b011;
    localparam logic [2:0] JMP_JALR = 3'b100;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_STALL = 1'b1
    } state_t;

    // A load still in MEM has no result yet, so EX/MEM forwarding is only for ALU producers.
    function automatic logic [1:0] fwd_sel(
        input logic       valid,
        input logic [4:0] src,
        input logic       rw_mem,
        input logic       mr_mem,
        input logic [4:0] rd_mem,
        input logic       rw_wb,
        input logic [4:0] rd_wb
    );
        if (!valid)                                 return FWD_RF;
        else if (rw_mem && !mr_mem && rd_mem == src) return FWD_EXMEM;
        else if (rw_wb && rd_wb == src)             return FWD_MEMWB;
        else                                        return FWD_RF;
    endfunction

endpackage

// File: rtl/branch_hazard_detect.sv
// rtl/branch_hazard_detect.sv - combinational branch operand hazard classifier and forward selects
module branch_hazard_detect
    import branch_hazard_ctrl_pkg::*;
(
    input  logic       IsBranch_ID,
    input  logic       UsesRt_ID,
    input  logic [4:0] Rs_ID,
    input  logic [4:0] Rt_ID,
    input  logic       RegWrite_EX,
    input  logic       MemRead_EX,
    input  logic [4:0] Rd_EX,
    input  logic       RegWrite_MEM,
    input  logic       MemRead_MEM,
    input  logic [4:0] Rd_MEM,
    input  logic       RegWrite_WB,
    input  logic [4:0] Rd_WB,
    output logic [1:0] stall_need,
    output logic [1:0] fwd1,
    output logic [1:0] fwd2
);

    logic rs_valid;
    logic rt_valid;
    logic ex_hit;
    logic mem_hit;

    assign rs_valid = (Rs_ID != 5'd0);
    assign rt_valid = UsesRt_ID && (Rt_ID != 5'd0);
    assign ex_hit   = (rs_valid && Rd_EX == Rs_ID) || (rt_valid && Rd_EX == Rt_ID);
    assign mem_hit  = (rs_valid && Rd_MEM == Rs_ID) || (rt_valid && Rd_MEM == Rt_ID);

    always_comb begin
        stall_need = 2'd0;
        if (IsBranch_ID) begin
            if (MemRead_EX && ex_hit)
                stall_need = 2'd2;
            else if ((RegWrite_EX && ex_hit) || (MemRead_MEM && mem_hit))
                stall_need = 2'd1;
        end
    end

    assign fwd1 = fwd_sel(rs_valid, Rs_ID, RegWrite_MEM, MemRead_MEM, Rd_MEM, RegWrite_WB, Rd_WB);
    assign fwd2 = fwd_sel(rt_valid, Rt_ID, RegWrite_MEM, MemRead_MEM, Rd_MEM, RegWrite_WB, Rd_WB);

endmodule

// File: rtl/branch_hazard_ctrl.sv
// rtl/branch_hazard_ctrl.sv - ID-stage branch stall FSM, next-PC/flush arbitration and statistics
module branch_hazard_ctrl
    import branch_hazard_ctrl_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             IsBranch_IF,
    input  logic             IsBranch_ID,
    input  logic             UsesRt_ID,
    input  logic [4:0]       Rs_ID,
    input  logic [4:0]       Rt_ID,
    input  logic             RegWrite_EX,
    input  logic             MemRead_EX,
    input  logic [4:0]       Rd_EX,
    input  logic             RegWrite_MEM,
    input  logic             MemRead_MEM,
    input  logic [4:0]       Rd_MEM,
    input  logic             RegWrite_WB,
    input  logic [4:0]       Rd_WB,
    input  logic             Taken_ID,
    input  logic [2:0]       JumpSignal,
    output logic [2:0]       NextPCSignal,
    output logic             IF_Flush,
    output logic             Stall_PC,
    output logic             Stall_IFID,
    output logic             Bubble_IDEX,
    output logic [1:0]       Fwd1Sel,
    output logic [1:0]       Fwd2Sel,
    output logic [CNT_W-1:0] BranchCnt,
    output logic [CNT_W-1:0] MispredCnt,
    output logic [CNT_W-1:0] StallCnt
);

    state_t     state, state_n;
    logic [1:0] cnt, cnt_n;
    logic [1:0] stall_need;
    logic [1:0] fwd1, fwd2;
    logic       stall_now;
    logic       resolve;

    branch_hazard_detect u_detect (
        .IsBranch_ID  (IsBranch_ID),
        .UsesRt_ID    (UsesRt_ID),
        .Rs_ID        (Rs_ID),
        .Rt_ID        (Rt_ID),
        .RegWrite_EX  (RegWrite_EX),
        .MemRead_EX   (MemRead_EX),
        .Rd_EX        (Rd_EX),
        .RegWrite_MEM (RegWrite_MEM),
        .MemRead_MEM  (MemRead_MEM),
        .Rd_MEM       (Rd_MEM),
        .RegWrite_WB  (RegWrite_WB),
        .Rd_WB        (Rd_WB),
        .stall_need   (stall_need),
        .fwd1         (fwd1),
        .fwd2         (fwd2)
    );

    // The detecting IDLE cycle is the first stall; STALL with cnt==1 is the resolve cycle,
    // so a branch needing n stalls sees exactly n stall cycles.
    assign stall_now = !rst && ((state == ST_IDLE  && stall_need != 2'd0) ||
                                (state == ST_STALL && cnt != 2'd1));
    assign resolve   = !rst && !stall_now && IsBranch_ID;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            cnt   <= 2'd0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        case (state)
            ST_IDLE: begin
                if (stall_need != 2'd0) begin
                    state_n = ST_STALL;
                    cnt_n   = stall_need;
                end
            end
            ST_STALL: begin
                cnt_n = cnt - 2'd1;
                if (cnt == 2'd1)
                    state_n = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_comb begin
        NextPCSignal = NPC_SEQ;
        IF_Flush     = 1'b0;
        Stall_PC     = 1'b0;
        Stall_IFID   = 1'b0;
        Bubble_IDEX  = 1'b0;
        Fwd1Sel      = rst ? FWD_RF : fwd1;
        Fwd2Sel      = rst ? FWD_RF : fwd2;
        if (rst) begin
            NextPCSignal = NPC_SEQ;
        end else if (stall_now) begin
            Stall_PC    = 1'b1;
            Stall_IFID  = 1'b1;
            Bubble_IDEX = 1'b1;
        end else if (IsBranch_ID) begin
            if (!Taken_ID) begin
                NextPCSignal = NPC_RESTORE;
                IF_Flush     = 1'b1;
            end
        end else if (JumpSignal == JMP_J || JumpSignal == JMP_JAL) begin
            NextPCSignal = NPC_J;
            IF_Flush     = 1'b1;
        end else if (JumpSignal == JMP_JR || JumpSignal == JMP_JALR) begin
            NextPCSignal = NPC_JR;
            IF_Flush     = 1'b1;
        end else if (IsBranch_IF) begin
            NextPCSignal = NPC_BR;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            BranchCnt  <= '0;
            MispredCnt <= '0;
            StallCnt   <= '0;
        end else begin
            if (resolve && BranchCnt != '1)
                BranchCnt <= BranchCnt + CNT_W'(1);
            if (resolve && !Taken_ID && MispredCnt != '1)
                MispredCnt <= MispredCnt + CNT_W'(1);
            if (stall_now && StallCnt != '1)
                StallCnt <= StallCnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_branch_hazard_ctrl.sv
// tb/tb_branch_hazard_ctrl.sv - scoreboard bench for branch_hazard_ctrl
module tb_branch_hazard_ctrl;

    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          IsBranch_IF, IsBranch_ID, UsesRt_ID;
    logic [4:0]    Rs_ID, Rt_ID;
    logic          RegWrite_EX, MemRead_EX;
    logic [4:0]    Rd_EX;
    logic          RegWrite_MEM, MemRead_MEM;
    logic [4:0]    Rd_MEM;
    logic          RegWrite_WB;
    logic [4:0]    Rd_WB;
    logic          Taken_ID;
    logic [2:0]    JumpSignal;
    logic [2:0]    NextPCSignal;
    logic          IF_Flush, Stall_PC, Stall_IFID, Bubble_IDEX;
    logic [1:0]    Fwd1Sel, Fwd2Sel;
    logic [CW-1:0] BranchCnt, MispredCnt, StallCnt;

    typedef struct packed {
        logic [2:0] npc;
        logic       flush;
        logic       spc;
        logic       sifid;
        logic       bub;
        logic [1:0] f1;
        logic [1:0] f2;
    } out_t;

    out_t          obs;
    out_t          exp_o;
    out_t          sb[$];
    logic [3*CW-1:0] cnts;
    int            checks = 0;
    int            errors = 0;

    assign obs  = {NextPCSignal, IF_Flush, Stall_PC, Stall_IFID, Bubble_IDEX, Fwd1Sel, Fwd2Sel};
    assign cnts = {BranchCnt, MispredCnt, StallCnt};

    branch_hazard_ctrl #(.CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .IsBranch_IF(IsBranch_IF), .IsBranch_ID(IsBranch_ID),
        .UsesRt_ID(UsesRt_ID), .Rs_ID(Rs_ID), .Rt_ID(Rt_ID),
        .RegWrite_EX(RegWrite_EX), .MemRead_EX(MemRead_EX), .Rd_EX(Rd_EX),
        .RegWrite_MEM(RegWrite_MEM), .MemRead_MEM(MemRead_MEM), .Rd_MEM(Rd_MEM),
        .RegWrite_WB(RegWrite_WB), .Rd_WB(Rd_WB), .Taken_ID(Taken_ID),
        .JumpSignal(JumpSignal), .NextPCSignal(NextPCSignal), .IF_Flush(IF_Flush),
        .Stall_PC(Stall_PC), .Stall_IFID(Stall_IFID), .Bubble_IDEX(Bubble_IDEX),
        .Fwd1Sel(Fwd1Sel), .Fwd2Sel(Fwd2Sel),
        .BranchCnt(BranchCnt), .MispredCnt(MispredCnt), .StallCnt(StallCnt)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    function automatic out_t mk(input logic [2:0] npc, input logic flush, input logic stall,
                                input logic [1:0] f1, input logic [1:0] f2);
        mk = {npc, flush, stall, stall, stall, f1, f2};
    endfunction

    function automatic logic [3*CW-1:0] mkc(input int br, input int mp, input int st);
        mkc = {CW'(br), CW'(mp), CW'(st)};
    endfunction

    task automatic clear_inputs();
        IsBranch_IF = 0; IsBranch_ID = 0; UsesRt_ID = 0; Rs_ID = 0; Rt_ID = 0;
        RegWrite_EX = 0; MemRead_EX = 0; Rd_EX = 0;
        RegWrite_MEM = 0; MemRead_MEM = 0; Rd_MEM = 0;
        RegWrite_WB = 0; Rd_WB = 0; Taken_ID = 0; JumpSignal = 3'b000;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_inputs();
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_inputs();
        IsBranch_ID = 1; Rs_ID = 5; RegWrite_EX = 1; MemRead_EX = 1; Rd_EX = 5; JumpSignal = 3'b010;
        #1;
        checks++;
        if (obs !== out_t'(0)) begin errors++; $display("FAIL reset_outputs got %h want %h", obs, out_t'(0)); end
        checks++;
        if (cnts !== mkc(0, 0, 0)) begin errors++; $display("FAIL reset_counters got %h want %h", cnts, mkc(0, 0, 0)); end
        @(posedge clk); #1;
        rst = 1'b0;
        clear_inputs();
    endtask

    task automatic test_not_taken();
        do_reset();
        IsBranch_ID = 1; UsesRt_ID = 1; Rs_ID = 1; Rt_ID = 2; Taken_ID = 0;
        sb.push_back(mk(3'b010, 1, 0, 2'b00, 2'b00));
        @(negedge clk); checks++; exp_o = sb.pop_front();
        if (obs !== exp_o) begin errors++; $display("FAIL not_taken got %h want %h", obs, exp_o); end
        @(posedge clk); #1;
        clear_inputs();
        @(negedge clk); checks++;
        if (cnts !== mkc(1, 1, 0)) begin errors++; $display("FAIL not_taken_cnt got %h want %h", cnts, mkc(1, 1, 0)); end
        @(posedge clk); #1;
    endtask

    task automatic test_load_ex();
        do_reset();
        IsBranch_ID = 1; UsesRt_ID = 1; Rs_ID = 5; Rt_ID = 3;
        RegWrite_EX = 1; MemRead_EX = 1; Rd_EX = 5;
        sb.push_back(mk(3'b000, 0, 1, 2'b00, 2'b00));
        @(negedge clk); checks++; exp_o = sb.pop_front();
        if (obs !== exp_o) begin errors++; $display("FAIL load_ex_s1 got %h want %h", obs, exp_o); end
        @(posedge clk); #1;
        RegWrite_EX = 0; MemRead_EX = 0; Rd_EX = 0;
        RegWrite_MEM = 1; MemRead_MEM = 1; Rd_MEM = 5;
        sb.push_back(mk(3'b000, 0, 1, 2'b00, 2'b00));
        @(negedge clk); checks++; exp_o = sb.pop_front();
        if (obs !== exp_o) begin errors++; $display("FAIL load_ex_s2 got %h want %h", obs, exp_o); end
        @(posedge clk); #1;
        RegWrite_MEM = 0; MemRead_MEM = 0; Rd_MEM = 0;
        RegWrite_WB = 1; Rd_WB = 5; Taken_ID = 1;
        sb.push_back(mk(3'b000, 0, 0, 2'b10, 2'b00));
        @(negedge clk); checks++; exp_o = sb.pop_front();
        if (obs !== exp_o) begin errors++; $display("FAIL load_ex_resolve got %h want %h", obs, exp_o); end
        @(posedge clk); #1;
        clear_inputs();
        @(negedge clk); checks++;
        if (cnts !== mkc(1, 0, 2)) begin errors++; $display("FAIL load_ex_cnt got %h want %h", cnts, mkc(1, 0, 2)); end
        @(posedge clk); #1;
    endtask

    task automatic test_alu_ex();
        do_reset();
        IsBranch_ID = 1; UsesRt_ID = 1; Rs_ID = 4; Rt_ID = 7;
        RegWrite_EX = 1; Rd_EX = 7;
        sb.push_back(mk(3'b000, 0, 1, 2'b00, 2'b00));
        @(negedge clk); checks++; exp_o = sb.pop_front();
        if (obs !== exp_o) begin errors++; $display("FAIL alu_ex_s1 got %h want %h", obs, exp_o); end
        @(posedge clk); #1;
        RegWrite_EX = 0; Rd_EX = 0; RegWrite_MEM = 1; Rd_MEM = 7; Taken_ID = 1;
        sb.push_back(mk(3'b000, 0, 0, 2'b00, 2'b01));
        @(negedge clk); checks++; exp_o = sb.pop_front();
        if (obs !== exp_o) begin errors++; $display("FAIL alu_ex_resolve got %h want %h", obs, exp_o); end
        @(posedge clk); #1;
        clear_inputs();
        @(negedge clk); checks++;
        if (cnts !== mkc(1, 0, 1)) begin errors++; $display("FAIL alu_ex_cnt got %h want %h", cnts, mkc(1, 0, 1)); end
        @(posedge clk); #1;
    endtask

    task automatic test_zero_reg();
        do_reset();
        IsBranch_ID = 1; UsesRt_ID = 0; Rs_ID = 0; Taken_ID = 1;
        RegWrite_EX = 1; Rd_EX = 0; RegWrite_MEM = 1; Rd_MEM = 0;
        sb.push_back(mk(3'b000, 0, 0, 2'b00, 2'b00));
        @(negedge clk); checks++; exp_o = sb.pop_front();
        if (obs !== exp_o) begin errors++; $display("FAIL zero_reg got %h want %h", obs, exp_o); end
        @(posedge clk); #1;
        Rs_ID = 2; Rt_ID = 6; Taken_ID = 0; Rd_EX = 6; Rd_MEM = 6;
        sb.push_back(mk(3'b010, 1, 0, 2'b00, 2'b00));
        @(negedge clk); checks++; exp_o = sb.pop_front();
        if (obs !== exp_o) begin errors++; $display("FAIL rt_unused got %h want %h", obs, exp_o); end
        @(posedge clk); #1;
        clear_inputs();
        @(negedge clk); checks++;
        if (cnts !== mkc(2, 1, 0)) begin errors++; $display("FAIL zero_reg_cnt got %h want %h", cnts, mkc(2, 1, 0)); end
        @(posedge clk); #1;
    endtask

    task automatic test_load_mem();
        do_reset();
        IsBranch_ID = 1; Rs_ID = 8; RegWrite_MEM = 1; MemRead_MEM = 1; Rd_MEM = 8;
        sb.push_back(mk(3'b000, 0, 1, 2'b00, 2'b00));
        @(negedge clk); checks++; exp_o = sb.pop_front();
        if (obs !== exp_o) begin errors++; $display("FAIL load_mem_s1 got %h want %h", obs, exp_o); end
        @(posedge clk); #1;
        RegWrite_MEM = 0; MemRead_MEM = 0; Rd_MEM = 0; RegWrite_WB = 1; Rd_WB = 8; Taken_ID = 1;
        sb.push_back(mk(3'b000, 0, 0, 2'b10, 2'b00));
        @(negedge clk); checks++; exp_o = sb.pop_front();
        if (obs !== exp_o) begin errors++; $display("FAIL load_mem_resolve got %h want %h", obs, exp_o); end
        @(posedge clk); #1;
        clear_inputs();
        @(negedge clk); checks++;
        if (cnts !== mkc(1, 0, 1)) begin errors++; $display("FAIL load_mem_cnt got %h want %h", cnts, mkc(1, 0, 1)); end
        @(posedge clk); #1;
    endtask

    task automatic test_jump_priority();
        do_reset();
        JumpSignal = 3'b011; IsBranch_IF = 1;
        sb.push_back(mk(3'b100, 1, 0, 2'b00, 2'b00));
        @(negedge clk); checks++; exp_o = sb.pop_front();
        if (obs !== exp_o) begin errors++; $display("FAIL jr_over_if got %h want %h", obs, exp_o); end
        @(posedge clk); #1;
        JumpSignal = 3'b111;
        sb.push_back(mk(3'b011, 1, 0, 2'b00, 2'b00));
        @(negedge clk); checks++; exp_o = sb.pop_front();
        if (obs !== exp_o) begin errors++; $display("FAIL jal_target got %h want %h", obs, exp_o); end
        @(posedge clk); #1;
        JumpSignal = 3'b000;
        sb.push_back(mk(3'b001, 0, 0, 2'b00, 2'b00));
        @(negedge clk); checks++; exp_o = sb.pop_front();
        if (obs !== exp_o) begin errors++; $display("FAIL if_predict got %h want %h", obs, exp_o); end
        @(posedge clk); #1;
        IsBranch_ID = 1; Rs_ID = 9; RegWrite_EX = 1; Rd_EX = 9; JumpSignal = 3'b010;
        sb.push_back(mk(3'b000, 0, 1, 2'b00, 2'b00));
        @(negedge clk); checks++; exp_o = sb.pop_front();
        if (obs !== exp_o) begin errors++; $display("FAIL stall_ignores_jump got %h want %h", obs, exp_o); end
        @(posedge clk); #1;
        RegWrite_EX = 0; Rd_EX = 0; RegWrite_MEM = 1; Rd_MEM = 9; Taken_ID = 1;
        sb.push_back(mk(3'b000, 0, 0, 2'b01, 2'b00));
        @(negedge clk); checks++; exp_o = sb.pop_front();
        if (obs !== exp_o) begin errors++; $display("FAIL branch_over_jump got %h want %h", obs, exp_o); end
        @(posedge clk); #1;
        clear_inputs();
    endtask

    task automatic test_reset_mid_stall();
        do_reset();
        IsBranch_ID = 1; Rs_ID = 5; RegWrite_EX = 1; MemRead_EX = 1; Rd_EX = 5;
        sb.push_back(mk(3'b000, 0, 1, 2'b00, 2'b00));
        @(negedge clk); checks++; exp_o = sb.pop_front();
        if (obs !== exp_o) begin errors++; $display("FAIL mid_stall_s1 got %h want %h", obs, exp_o); end
        @(posedge clk); #1;
        RegWrite_EX = 0; MemRead_EX = 0; Rd_EX = 0; RegWrite_MEM = 1; MemRead_MEM = 1; Rd_MEM = 5;
        sb.push_back(mk(3'b000, 0, 1, 2'b00, 2'b00));
        @(negedge clk); checks++; exp_o = sb.pop_front();
        if (obs !== exp_o) begin errors++; $display("FAIL mid_stall_s2 got %h want %h", obs, exp_o); end
        #1 rst = 1'b1;
        #1;
        checks++;
        if (obs !== out_t'(0)) begin errors++; $display("FAIL mid_stall_rst_out got %h want %h", obs, out_t'(0)); end
        checks++;
        if (cnts !== mkc(0, 0, 0)) begin errors++; $display("FAIL mid_stall_rst_cnt got %h want %h", cnts, mkc(0, 0, 0)); end
        @(posedge clk); #1;
        rst = 1'b0;
        clear_inputs();
        IsBranch_ID = 1; Rs_ID = 1; Taken_ID = 0;
        sb.push_back(mk(3'b010, 1, 0, 2'b00, 2'b00));
        @(negedge clk); checks++; exp_o = sb.pop_front();
        if (obs !== exp_o) begin errors++; $display("FAIL post_rst_idle got %h want %h", obs, exp_o); end
        checks++;
        if (cnts !== mkc(0, 0, 0)) begin errors++; $display("FAIL post_rst_cnt got %h want %h", cnts, mkc(0, 0, 0)); end
        @(posedge clk); #1;
        clear_inputs();
        @(negedge clk); checks++;
        if (cnts !== mkc(1, 1, 0)) begin errors++; $display("FAIL post_rst_count got %h want %h", cnts, mkc(1, 1, 0)); end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int i = 0; i < 20; i++) begin
            IsBranch_ID = 1; Rs_ID = 5'(3 + (i % 4)); Taken_ID = 0;
            sb.push_back(mk(3'b010, 1, 0, 2'b00, 2'b00));
            @(negedge clk); checks++; exp_o = sb.pop_front();
            if (obs !== exp_o) begin errors++; $display("FAIL b2b_%0d got %h want %h", i, obs, exp_o); end
            @(posedge clk); #1;
        end
        clear_inputs();
        @(negedge clk); checks++;
        if (cnts !== mkc(15, 15, 0)) begin errors++; $display("FAIL saturate_cnt got %h want %h", cnts, mkc(15, 15, 0)); end
        @(posedge clk); #1;
    endtask

    initial begin
        clear_inputs();
        rst = 1'b1;
        test_reset();
        test_not_taken();
        test_load_ex();
        test_alu_ex();
        test_zero_reg();
        test_load_mem();
        test_jump_priority();
        test_reset_mid_stall();
        test_back_to_back();
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover got %0d want 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/branch_hazard_ctrl.md
# branch_hazard_ctrl

Sequencing controller for the ID-stage branch resolution path in the 5-stage MIPS pipeline. It detects when a branch in ID reads a register still being produced in EX or MEM, and inserts 1 or 2 stall cycles through a small FSM. It selects forwarding sources for the branch comparator operands. After resolution it arbitrates the next-PC select and IF flush between the IF-stage predict-taken request, the ID-stage branch verdict and the ID-stage jumps. It also keeps saturating branch statistics counters.

## Interface

Parameters:
- `CNT_W`, default 16: width of each statistics counter.

Ports:
- `clk` in 1: clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `IsBranch_IF` in 1: a conditional branch (BEQ/BNE/BGTZ/BLEZ/REGIMM) is in IF.
- `IsBranch_ID` in 1: a conditional branch is in ID.
- `UsesRt_ID` in 1: the branch in ID compares Rt (BEQ/BNE).
- `Rs_ID`, `Rt_ID` in 5: branch source registers.
- `RegWrite_EX`, `MemRead_EX` in 1: EX-stage producer flags.
- `Rd_EX` in 5: EX-stage destination register.
- `RegWrite_MEM`, `MemRead_MEM` in 1: MEM-stage producer flags.
- `Rd_MEM` in 5: MEM-stage destination register.
- `RegWrite_WB` in 1: WB-stage write flag.
- `Rd_WB` in 5: WB-stage destination register.
- `Taken_ID` in 1: comparator verdict for the branch in ID, using forwarded operands.
- `JumpSignal` in 3: ID jump class. 010/111 select the jump target; 011/100 select the jump register.
- `NextPCSignal` out 3: next-PC select. 000 = PC+4, 001 = branch target (predict taken), 010 = fall-through restore, 011 = jump target, 100 = jump register.
- `IF_Flush` out 1: squash the IF/ID register.
- `Stall_PC`, `Stall_IFID` out 1: hold the PC and the IF/ID register.
- `Bubble_IDEX` out 1: insert a NOP into ID/EX.
- `Fwd1Sel`, `Fwd2Sel` out 2: comparator operand source. 00 = register file, 01 = EX/MEM result, 10 = MEM/WB result.
- `BranchCnt`, `MispredCnt`, `StallCnt` out `CNT_W`: statistics counters.

## Operation

- **Hazard classification** is combinational and applies only when `IsBranch_ID`=1.
  - A source is Rs always, and Rt only when `UsesRt_ID`=1. Register 0 never hazards.
  - Need 2 stalls: `MemRead_EX` with `Rd_EX` matching a source.
  - Need 1 stall: `RegWrite_EX` with `MemRead_EX`=0 and `Rd_EX` matching; or `MemRead_MEM` with `Rd_MEM` matching.
  - Otherwise no stall.
- **FSM states**: IDLE, STALL. There is a 2-bit `cnt`.
  - IDLE, with a branch needing n>0 stalls → go to STALL and load `cnt`=n. Stall outputs are asserted in this same cycle.
  - STALL → assert stall outputs and decrement `cnt`. When `cnt`=1, return to IDLE.
  - In IDLE with no hazard, the branch resolves in that cycle.
- **Stall outputs** (asserted together): `Stall_PC`=`Stall_IFID`=`Bubble_IDEX`=1, `NextPCSignal`=000, `IF_Flush`=0.
  - While stalling, the IF predict and ID jump requests are ignored.
- **Forward select**, per source, in priority order:
  - 01 if `RegWrite_MEM` & !`MemRead_MEM` & `Rd_MEM`==src.
  - else 10 if `RegWrite_WB` & `Rd_WB`==src.
  - else 00.
  - Register 0 always selects 00.
- **Next-PC priority** in non-stall cycles:
  1. ID branch not taken → 010 with flush. The codebase predicts taken.
  2. ID branch taken → 000, no flush (target already fetched).
  3. `JumpSignal` 010/111 → 011 with flush.
  4. `JumpSignal` 011/100 → 100 with flush.
  5. `IsBranch_IF` → 001, no flush.
  6. Otherwise → 000.
  - A branch in ID and a jump in ID cannot coexist. If both are asserted, the branch wins.
- **Counters** saturate at all-ones.
  - `BranchCnt` increments once per resolved branch (the non-stall cycle with `IsBranch_ID`).
  - `MispredCnt` increments when a resolved branch is not taken.
  - `StallCnt` increments every stall cycle.

## Timing

- **Reset values**: state IDLE, `cnt`=0, all counters 0. Combinational outputs during reset: all 0, `NextPCSignal`=000.
- **Reset mid-STALL**: return to IDLE immediately and drop the stall outputs asynchronously.
- **Output timing**: all control outputs are combinational from state and inputs (Mealy). Only the state, `cnt` and the counters are registered.
- **Branch latency**:
  - No hazard: resolves in the ID cycle.
  - ALU producer in EX, or load in MEM: 1 stall cycle, resolves in the next cycle.
  - Load in EX: 2 stall cycles, resolves in the third ID cycle.
- **Hazard re-evaluation**: no second hazard check occurs during STALL. The stall counts are sized so that the producer has advanced far enough to forward when the branch resolves.

## Structure

- Shared `ControlSignalDefine.v` gains NextPC select codes (`NPC_SEQ`, `NPC_BR`, `NPC_RESTORE`, `NPC_J`, `NPC_JR`), forward select codes, and FSM state codes.
- One natural sub-module: `branch_hazard_detect`, the combinational classifier that outputs the stall count (0/1/2) and the forward selects.

## Test plan

- BEQ in ID, no producers, `Taken_ID`=0 → `NextPCSignal`=010, `IF_Flush`=1, no stall; `BranchCnt`=1, `MispredCnt`=1.
- `lw $5` in EX, BEQ in ID reading `$5` → 2 cycles of `Stall_PC`=`Bubble_IDEX`=1, then resolve with `Fwd1Sel`=10; `StallCnt`=2.
- `add $7` in EX, BNE in ID with Rt=`$7` → 1 stall cycle, then `Fwd2Sel`=01. With `Taken_ID`=1 → `NextPCSignal`=000, no flush.
- ALU writer of `$0` in EX, BGTZ reading `$0` → no stall, `Fwd1Sel`=00.
- `rst` pulsed during the second cycle of a 2-cycle stall → outputs go to 0 immediately; after release, state is IDLE and all counters are 0.
- `JumpSignal`=011 with `IsBranch_IF`=1 → `NextPCSignal`=100, `IF_Flush`=1. Separately, `IsBranch_IF` alone → 001, no flush. Counter forced to all-ones does not wrap on a further increment.
